// File: rtl/as2650_io_pkg.sv
// Shared register map, bit positions and reset constants for the AS2650 I/O responder.
package as2650_io_pkg;

  localparam logic [2:0] REG_GPO    = 3'd0;
  localparam logic [2:0] REG_GPI    = 3'd1;
  localparam logic [2:0] REG_RELOAD = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_RXD    = 3'd6;
  localparam logic [2:0] REG_RSVD   = 3'd7;

  localparam int CTRL_TEN  = 0;
  localparam int CTRL_SSEL = 1;

  localparam int ST_EXPIRED = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_FLAG    = 4;

  localparam logic [7:0] RELOAD_RST = 8'hFF;
  localparam logic [7:0] COUNT_RST  = 8'hFF;
  localparam logic [7:0] GPO_RST    = 8'h00;

endpackage

// File: rtl/as2650_io_responder_if.sv
// CPU I/O bus as seen between the AS2650 core (master) and a responder (slave).
interface as2650_io_responder_if;
  logic [12:0] adr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        hit;
  logic        opreq;
  logic        m_io;
  logic        rw;
  logic        wrp;
  logic        d_c;
  logic        flag;
  logic        sense;

  modport master (
    output adr, cpu_dout, opreq, m_io, rw, wrp, d_c, flag,
    input  cpu_din, hit, sense
  );

  modport slave (
    input  adr, cpu_dout, opreq, m_io, rw, wrp, d_c, flag,
    output cpu_din, hit, sense
  );
endinterface

// File: rtl/as2650_rx_fifo.sv
// Small RX byte FIFO; pop of an empty FIFO and push into a full one (without pop) are ignored.
module as2650_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_pop;
  logic              do_push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/as2650_io_responder.sv
// AS2650 I/O-space responder: GPIO latch, synchronised inputs, prescaled reload timer, RX FIFO.
module as2650_io_responder
  import as2650_io_pkg::*;
#(
  parameter logic [4:0] BASE_PORT  = 5'h1F,
  parameter int         PRESCALE   = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  as2650_io_responder_if.slave   bus,
  output logic [7:0]             gpio_out,
  input  logic [7:0]             gpio_in,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic            opreq_q;
  logic            armed;
  logic [7:0]      gpi_s1;
  logic [7:0]      gpi_s2;
  logic [7:0]      reload;
  logic [7:0]      count;
  logic [1:0]      ctrl;
  logic [PS_W-1:0] presc;
  logic            expired;
  logic            overflow;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic [2:0]      sel;
  logic            start;
  logic            rd_start;
  logic            wr_en;
  logic            reload_wr;
  logic            status_wr;
  logic            tick;
  logic            set_exp;
  logic            set_ovf;
  logic [7:0]      status;
  logic [7:0]      rd_mux;
  logic            unused_ok;

  assign unused_ok = &{1'b0, bus.d_c, bus.adr[12:8]};

  assign sel       = bus.adr[2:0];
  assign bus.hit   = bus.opreq & ~bus.m_io & (bus.adr[7:3] == BASE_PORT);
  // armed stays low after reset until opreq has been seen low, so a held request never restarts.
  assign start     = bus.hit & ~opreq_q & armed;
  assign rd_start  = start & ~bus.rw;
  assign wr_en     = bus.hit & bus.rw & bus.wrp;
  assign reload_wr = wr_en & (sel == REG_RELOAD);
  assign status_wr = wr_en & (sel == REG_STATUS);
  assign tick      = ctrl[CTRL_TEN] & (presc == PS_LAST);
  assign fifo_pop  = rd_start & (sel == REG_RXD) & ~fifo_empty;
  assign set_ovf   = rx_valid & fifo_full & ~fifo_pop;
  assign set_exp   = tick & ~reload_wr & (count == 8'd0);

  always_comb begin
    status               = 8'h00;
    status[ST_EXPIRED]   = expired;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_OVF]       = overflow;
    status[ST_FLAG]      = bus.flag;
    rd_mux               = 8'h00;
    case (sel)
      REG_GPO:    rd_mux = gpio_out;
      REG_GPI:    rd_mux = gpi_s2;
      REG_RELOAD: rd_mux = reload;
      REG_COUNT:  rd_mux = count;
      REG_CTRL:   rd_mux = {6'b000000, ctrl};
      REG_STATUS: rd_mux = status;
      REG_RXD:    rd_mux = fifo_empty ? 8'h00 : fifo_rdata;
      REG_RSVD:   rd_mux = 8'h00;
      default:    rd_mux = 8'h00;
    endcase
  end

  as2650_rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (fifo_pop),
    .wdata (rx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      opreq_q     <= 1'b0;
      armed       <= 1'b0;
      bus.cpu_din <= 8'h00;
      bus.sense   <= 1'b0;
      gpio_out    <= GPO_RST;
      gpi_s1      <= 8'h00;
      gpi_s2      <= 8'h00;
      reload      <= RELOAD_RST;
      count       <= COUNT_RST;
      ctrl        <= 2'b00;
      presc       <= '0;
      expired     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      opreq_q   <= bus.opreq;
      armed     <= armed | ~bus.opreq;
      gpi_s1    <= gpio_in;
      gpi_s2    <= gpi_s1;
      bus.sense <= ctrl[CTRL_SSEL] ? ~fifo_empty : expired;

      if (rd_start) bus.cpu_din <= rd_mux;
      if (wr_en && (sel == REG_GPO))  gpio_out <= bus.cpu_dout;
      if (wr_en && (sel == REG_CTRL)) ctrl     <= bus.cpu_dout[1:0];

      // A RELOAD write restarts the timer and takes priority over a coincident tick.
      if (reload_wr) begin
        reload <= bus.cpu_dout;
        count  <= bus.cpu_dout;
        presc  <= '0;
      end else if (ctrl[CTRL_TEN]) begin
        if (tick) begin
          presc <= '0;
          count <= (count == 8'd0) ? reload : count - 8'd1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      // Sticky bits: a new event in the same cycle as a W1C keeps the bit set.
      expired  <= set_exp | (expired  & ~(status_wr & bus.cpu_dout[ST_EXPIRED]));
      overflow <= set_ovf | (overflow & ~(status_wr & bus.cpu_dout[ST_OVF]));
    end
  end

endmodule

// File: tb/tb_as2650_io_responder.sv
// Bench for as2650_io_responder: directed register-map scenarios plus randomized bus traffic vs a reference model.
module tb_as2650_io_responder;
  import as2650_io_pkg::*;

  localparam logic [4:0] BASE     = 5'h1F;
  localparam int         PRESCALE = 16;
  localparam int         DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  as2650_io_responder_if bus();

  as2650_io_responder #(
    .BASE_PORT  (BASE),
    .PRESCALE   (PRESCALE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model state, stepped once per rising edge from the inputs presented in that cycle.
  logic [7:0] m_gpo, m_reload, m_count, m_din, m_s1, m_s2;
  logic [1:0] m_ctrl;
  int         m_presc;
  bit         m_exp, m_ovf, m_sense, m_oq, m_armed;
  bit         m_valid = 0;
  logic [7:0] m_q[$];

  task automatic model_step();
    logic [7:0] rd;
    logic [2:0] r;
    bit h, start, wr, pop, nsense, set_e, set_o, clr_e, clr_o;
    if (rst) begin
      m_gpo = 8'h00; m_reload = 8'hFF; m_count = 8'hFF; m_din = 8'h00;
      m_s1 = 8'h00; m_s2 = 8'h00; m_ctrl = 2'b00; m_presc = 0;
      m_exp = 0; m_ovf = 0; m_sense = 0; m_oq = 0; m_armed = 0;
      m_q.delete();
      m_valid = 1;
      return;
    end
    r      = bus.adr[2:0];
    h      = bus.opreq && !bus.m_io && (bus.adr[7:3] == BASE);
    start  = h && !m_oq && m_armed;
    wr     = h && bus.rw && bus.wrp;
    nsense = m_ctrl[1] ? (m_q.size() != 0) : m_exp;
    pop = 0; set_e = 0; set_o = 0; rd = 8'h00;
    if (start && !bus.rw) begin
      case (r)
        3'd0: rd = m_gpo;
        3'd1: rd = m_s2;
        3'd2: rd = m_reload;
        3'd3: rd = m_count;
        3'd4: rd = {6'b0, m_ctrl};
        3'd5: rd = {3'b0, bus.flag, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0), m_exp};
        3'd6: begin pop = (m_q.size() != 0); rd = pop ? m_q[0] : 8'h00; end
        default: rd = 8'h00;
      endcase
      m_din = rd;
    end
    if (rx_valid && (m_q.size() == DEPTH) && !pop) set_o = 1;
    if (pop) void'(m_q.pop_front());
    if (rx_valid && !set_o) m_q.push_back(rx_data);
    if (wr && r == 3'd2) begin
      m_reload = bus.cpu_dout; m_count = bus.cpu_dout; m_presc = 0;
    end else if (m_ctrl[0]) begin
      if (m_presc == PRESCALE - 1) begin
        m_presc = 0;
        if (m_count == 0) begin m_count = m_reload; set_e = 1; end
        else m_count = m_count - 8'd1;
      end else m_presc++;
    end
    clr_e = wr && (r == 3'd5) && bus.cpu_dout[0];
    clr_o = wr && (r == 3'd5) && bus.cpu_dout[3];
    m_exp = set_e || (m_exp && !clr_e);
    m_ovf = set_o || (m_ovf && !clr_o);
    if (wr && r == 3'd0) m_gpo  = bus.cpu_dout;
    if (wr && r == 3'd4) m_ctrl = bus.cpu_dout[1:0];
    m_s2 = m_s1; m_s1 = gpio_in;
    m_oq = bus.opreq;
    m_armed = m_armed || !bus.opreq;
    m_sense = nsense;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_valid) begin
      check("cpu_din_model", bus.cpu_din, m_din);
      check("gpio_out_model", gpio_out, m_gpo);
      check("sense_model", {7'b0, bus.sense}, {7'b0, m_sense});
    end
  endtask

  task automatic access(input logic [7:0] port, input bit mio, input bit wr, input logic [7:0] d,
                        input int hold, input bit push_rx, input logic [7:0] rxb);
    bit exp_hit;
    bus.adr = {5'b0, port}; bus.m_io = mio; bus.rw = wr; bus.cpu_dout = d;
    bus.opreq = 1'b1; bus.wrp = wr; bus.d_c = 1'($urandom);
    if (push_rx) begin rx_valid = 1'b1; rx_data = rxb; end
    exp_hit = !mio && (port[7:3] == BASE);
    #1 check("hit", {7'b0, bus.hit}, {7'b0, exp_hit});
    cyc();
    rx_valid = 1'b0; bus.wrp = 1'b0;
    for (int i = 1; i < hold; i++) cyc();
    bus.opreq = 1'b0;
    cyc();
  endtask

  task automatic wr_reg(input logic [2:0] r, input logic [7:0] d);
    access({BASE, r}, 1'b0, 1'b1, d, 1, 1'b0, 8'h00);
  endtask

  task automatic rd_reg(input logic [2:0] r, output logic [7:0] d);
    access({BASE, r}, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h00);
    d = bus.cpu_din;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.opreq = 1'b0; bus.wrp = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] exp_rxd [4];
    int n;
    bus.adr = '0; bus.cpu_dout = '0; bus.opreq = 0; bus.m_io = 0; bus.rw = 0;
    bus.wrp = 0; bus.d_c = 0; bus.flag = 0;

    // Reset values
    do_reset();
    check("rst_cpu_din", bus.cpu_din, 8'h00);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_sense", {7'b0, bus.sense}, 8'h00);
    rd_reg(REG_RELOAD, v); check("rst_reload", v, 8'hFF);
    rd_reg(REG_COUNT, v);  check("rst_count", v, 8'hFF);
    rd_reg(REG_CTRL, v);   check("rst_ctrl", v, 8'h00);
    rd_reg(REG_STATUS, v); check("rst_status", v, 8'h02);
    rd_reg(REG_RSVD, v);   check("rsvd_read", v, 8'h00);

    // GPIO
    wr_reg(REG_GPO, 8'h5A); check("gpo_write", gpio_out, 8'h5A);
    rd_reg(REG_GPO, v);     check("gpo_read", v, 8'h5A);
    gpio_in = 8'hC3; cyc(); cyc();
    rd_reg(REG_GPI, v);     check("gpi_read", v, 8'hC3);

    // Timer: RELOAD=2, enable and count edges until sense (expired) appears
    wr_reg(REG_RELOAD, 8'h02);
    bus.adr = {5'b0, BASE, REG_CTRL}; bus.m_io = 0; bus.rw = 1; bus.cpu_dout = 8'h01;
    bus.wrp = 1; bus.opreq = 1;
    cyc();
    bus.wrp = 0; bus.opreq = 0;
    n = 101;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (bus.sense) begin n = i; break; end
    end
    check("expire_cycles", 8'(n), 8'd49);
    rd_reg(REG_COUNT, v);  check("count_reloaded", v, 8'h02);
    rd_reg(REG_STATUS, v); check("status_expired", v, 8'h03);
    wr_reg(REG_CTRL, 8'h03); cyc();
    check("sense_fifo_src", {7'b0, bus.sense}, 8'h00);
    wr_reg(REG_CTRL, 8'h01); cyc();
    check("sense_timer_src", {7'b0, bus.sense}, 8'h01);
    wr_reg(REG_CTRL, 8'h00);
    wr_reg(REG_STATUS, 8'h01);
    bus.flag = 1;
    rd_reg(REG_STATUS, v); check("status_w1c_flag", v, 8'h12);
    bus.flag = 0;

    // FIFO fill, overflow, drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    rd_reg(REG_STATUS, v); check("fifo_full", v, 8'h04);
    push(8'h55);
    rd_reg(REG_STATUS, v); check("fifo_ovf", v, 8'h0C);
    exp_rxd = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin rd_reg(REG_RXD, v); check("rxd_drain", v, exp_rxd[i]); end
    rd_reg(REG_RXD, v);    check("rxd_empty_pop", v, 8'h00);
    rd_reg(REG_STATUS, v); check("status_empty_ovf", v, 8'h0A);
    wr_reg(REG_STATUS, 8'h08);
    rd_reg(REG_STATUS, v); check("ovf_w1c", v, 8'h02);

    // Full FIFO with simultaneous push and pop
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    access({BASE, REG_RXD}, 1'b0, 1'b0, 8'h00, 1, 1'b1, 8'h66);
    check("pushpop_rd", bus.cpu_din, 8'h11);
    rd_reg(REG_STATUS, v); check("pushpop_status", v, 8'h04);
    exp_rxd = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin rd_reg(REG_RXD, v); check("pushpop_drain", v, exp_rxd[i]); end

    // Long opreq pops once
    push(8'hAA); push(8'hBB);
    access({BASE, REG_RXD}, 1'b0, 1'b0, 8'h00, 4, 1'b0, 8'h00);
    check("hold_pop_first", bus.cpu_din, 8'hAA);
    rd_reg(REG_RXD, v); check("hold_pop_second", v, 8'hBB);
    rd_reg(REG_RXD, v); check("hold_pop_empty", v, 8'h00);

    // Non-hits
    access({BASE, REG_GPO}, 1'b1, 1'b1, 8'h33, 1, 1'b0, 8'h00);
    check("mio_nochange", gpio_out, 8'h5A);
    access({5'h1E, REG_GPO}, 1'b0, 1'b1, 8'h44, 1, 1'b0, 8'h00);
    check("port_nochange", gpio_out, 8'h5A);

    // Reset while a read of RXD is in progress
    wr_reg(REG_GPO, 8'h77);
    push(8'hCC);
    bus.adr = {5'b0, BASE, REG_RXD}; bus.rw = 0; bus.m_io = 0; bus.opreq = 1; rst = 1;
    cyc(); cyc();
    check("midrst_cpu_din", bus.cpu_din, 8'h00);
    check("midrst_gpio_out", gpio_out, 8'h00);
    check("midrst_sense", {7'b0, bus.sense}, 8'h00);
    rst = 0;
    rx_valid = 1; rx_data = 8'hDD;
    cyc();
    rx_valid = 0;
    cyc(); cyc();
    check("held_opreq_no_start", bus.cpu_din, 8'h00);
    bus.opreq = 0; cyc();
    rd_reg(REG_RXD, v); check("held_opreq_no_pop", v, 8'hDD);

    // Randomized traffic against the model
    do_reset();
    wr_reg(REG_RELOAD, 8'h01);
    wr_reg(REG_CTRL, 8'h01);
    for (int t = 0; t < 300; t++) begin
      gpio_in  = 8'($urandom);
      bus.flag = 1'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        logic [7:0] port, d;
        logic [2:0] r;
        bit mio, wr;
        r    = 3'($urandom);
        port = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {BASE, r};
        mio  = ($urandom_range(0, 7) == 0);
        wr   = 1'($urandom);
        d    = 8'($urandom);
        if (port[2:0] == REG_RELOAD) d = 8'($urandom_range(0, 3));
        access(port, mio, wr, d, $urandom_range(1, 4), ($urandom_range(0, 2) == 0), 8'($urandom));
      end else begin
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          rx_valid = 1'($urandom); rx_data = 8'($urandom);
          cyc();
        end
        rx_valid = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
